// File: rtl/convo_frame_ctrl_if.sv
// Bus bundle between the pixel source, convo_frame_ctrl and the convolution datapath.
// The err line exists only when CONVO_FRAME_CTRL_ERR_EN is defined.
interface convo_frame_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 4
);
  logic              start;
  logic              pix_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              win_valid;
  logic [ADDR_W-1:0] rd_base;
  logic              res_valid;
  logic [CNT_W-1:0]  out_row;
  logic [CNT_W-1:0]  out_col;
  logic              busy;
  logic              done;
`ifdef CONVO_FRAME_CTRL_ERR_EN
  logic              err;
`endif

  // Pixel source / frame host side.
  modport master (
`ifdef CONVO_FRAME_CTRL_ERR_EN
    input  err,
`endif
    output start, pix_valid,
    input  wr_en, wr_addr, win_valid, rd_base, res_valid,
    input  out_row, out_col, busy, done
  );

  // Frame controller side.
  modport slave (
`ifdef CONVO_FRAME_CTRL_ERR_EN
    output err,
`endif
    input  start, pix_valid,
    output wr_en, wr_addr, win_valid, rd_base, res_valid,
    output out_row, out_col, busy, done
  );
endinterface

// File: rtl/convo_frame_ctrl.sv
// Frame sequencer for the RGB 3x3 convolution datapath: load N*N pixels, sweep windows, track results.
// Optional sticky protocol-error flag enabled by defining CONVO_FRAME_CTRL_ERR_EN.
module convo_frame_ctrl #(
  parameter int N        = 10,
  parameter int ADDR_W   = 7,
  parameter int CNT_W    = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  convo_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(N*N-1);
  localparam logic [CNT_W-1:0]    LAST_RC   = CNT_W'(N-3);
  localparam logic [PIPE_LAT-1:0] TAIL_ONLY = PIPE_LAT'(1) << (PIPE_LAT-1);

  state_t            state_r, state_nx;
  logic [ADDR_W-1:0] load_cnt_r, load_cnt_nx;
  logic [ADDR_W-1:0] rd_base_r, rd_base_nx;
  logic [CNT_W-1:0]  row_r, row_nx;
  logic [CNT_W-1:0]  col_r, col_nx;
  logic              win_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              wr_en_s;
  logic              last_res_s;
`ifdef CONVO_FRAME_CTRL_ERR_EN
  logic              err_r, err_nx;
`endif

  // Result-tracking pipeline: stage k holds the window issued k+1 cycles earlier.
  logic [PIPE_LAT-1:0]            v_pipe_r;
  logic [PIPE_LAT-1:0]            v_in_s;
  logic [PIPE_LAT-1:0][CNT_W-1:0] r_pipe_r, r_in_s;
  logic [PIPE_LAT-1:0][CNT_W-1:0] c_pipe_r, c_in_s;

  for (genvar k = 0; k < PIPE_LAT; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_in_s[k] = win_valid_r;
      assign r_in_s[k] = row_r;
      assign c_in_s[k] = col_r;
    end else begin : g_body
      assign v_in_s[k] = v_pipe_r[k-1];
      assign r_in_s[k] = r_pipe_r[k-1];
      assign c_in_s[k] = c_pipe_r[k-1];
    end
  end

  // Windows are issued back to back, so the last result is the lone valid at the tail.
  assign last_res_s = (v_pipe_r == TAIL_ONLY) && !win_valid_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, counter advance and write strobe.
  always_comb begin
    state_nx    = state_r;
    load_cnt_nx = load_cnt_r;
    rd_base_nx  = rd_base_r;
    row_nx      = row_r;
    col_nx      = col_r;
    wr_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx    = ST_LOAD;
          load_cnt_nx = '0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.pix_valid) begin
          wr_en_s = 1'b1;
          if (load_cnt_r == LAST_ADDR) begin
            state_nx   = ST_COMPUTE;
            rd_base_nx = '0;
            row_nx     = '0;
            col_nx     = '0;
          end else begin
            load_cnt_nx = load_cnt_r + ADDR_W'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_COMPUTE: begin
        if ((row_r == LAST_RC) && (col_r == LAST_RC)) begin
          state_nx = ST_DRAIN;
        end else if (col_r == LAST_RC) begin
          // Skip the two right-edge columns that cannot anchor a window.
          col_nx     = '0;
          row_nx     = row_r + CNT_W'(1);
          rd_base_nx = rd_base_r + ADDR_W'(3);
        end else begin
          col_nx     = col_r + CNT_W'(1);
          rd_base_nx = rd_base_r + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (last_res_s) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

`ifdef CONVO_FRAME_CTRL_ERR_EN
  // Sticky misuse flag: start while busy, or pixels offered outside the load phase.
  always_comb begin
    err_nx = err_r;
    if ((state_r == ST_IDLE) && bus.start) begin
      err_nx = 1'b0;
    end else if (bus.start && ((state_r == ST_LOAD) || (state_r == ST_COMPUTE) ||
                               (state_r == ST_DRAIN))) begin
      err_nx = 1'b1;
    end else if (bus.pix_valid && ((state_r == ST_COMPUTE) || (state_r == ST_DRAIN) ||
                                   (state_r == ST_DONE))) begin
      err_nx = 1'b1;
    end else begin
      err_nx = err_r;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_nx;
    end
  end

  assign bus.err = err_r;
`endif

  // Counters and registered frame outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_r  <= '0;
      rd_base_r   <= '0;
      row_r       <= '0;
      col_r       <= '0;
      win_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      load_cnt_r  <= load_cnt_nx;
      rd_base_r   <= rd_base_nx;
      row_r       <= row_nx;
      col_r       <= col_nx;
      win_valid_r <= (state_nx == ST_COMPUTE);
      busy_r      <= (state_nx == ST_LOAD) || (state_nx == ST_COMPUTE) ||
                     (state_nx == ST_DRAIN);
      done_r      <= (state_nx == ST_DONE);
    end
  end

  // Result pipeline; the tail row/col only load on a valid so they hold between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_pipe_r <= '0;
      r_pipe_r <= '0;
      c_pipe_r <= '0;
    end else begin
      v_pipe_r <= v_in_s;
      for (int k = 0; k < PIPE_LAT; k++) begin
        if ((k < PIPE_LAT-1) || v_in_s[k]) begin
          r_pipe_r[k] <= r_in_s[k];
          c_pipe_r[k] <= c_in_s[k];
        end
      end
    end
  end

  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr   = load_cnt_r;
  assign bus.win_valid = win_valid_r;
  assign bus.rd_base   = rd_base_r;
  assign bus.res_valid = v_pipe_r[PIPE_LAT-1];
  assign bus.out_row   = r_pipe_r[PIPE_LAT-1];
  assign bus.out_col   = c_pipe_r[PIPE_LAT-1];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_convo_frame_ctrl.sv
// Directed bench for convo_frame_ctrl (N=10, PIPE_LAT=4) with hand-computed expectations.
module tb_convo_frame_ctrl;
  localparam int N        = 10;
  localparam int ADDR_W   = 7;
  localparam int CNT_W    = 4;
  localparam int PIPE_LAT = 4;
  localparam int WINS     = (N-2)*(N-2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  convo_frame_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  convo_frame_ctrl #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;

  logic [ADDR_W-1:0]  q_wr[$];
  logic [ADDR_W-1:0]  q_win[$];
  logic [2*CNT_W-1:0] q_res[$];
  int   last_wr_cyc, first_win_cyc, first_res_cyc, last_res_cyc;
  int   done_cnt, done_cyc, start_cyc;
  logic busy_at_done, busy_before_done, prev_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Activity log sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en) begin
        q_wr.push_back(bus.wr_addr);
        last_wr_cyc = cyc;
      end
      if (bus.win_valid) begin
        q_win.push_back(bus.rd_base);
        if (q_win.size() == 1) first_win_cyc = cyc;
      end
      if (bus.res_valid) begin
        q_res.push_back({bus.out_row, bus.out_col});
        if (q_res.size() == 1) first_res_cyc = cyc;
        last_res_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc         = cyc;
        busy_at_done     = bus.busy;
        busy_before_done = prev_busy;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_cnt++;
    if (actual !== expected) begin
      errors_cnt++;
      $display("FAIL %s: actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_wr.delete();
    q_win.delete();
    q_res.delete();
    done_cnt         = 0;
    last_wr_cyc      = -1;
    first_win_cyc    = -1;
    first_res_cyc    = -1;
    last_res_cyc     = -1;
    done_cyc         = -1;
    busy_at_done     = 1'b1;
    busy_before_done = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},     32'(bus.wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
    check({tag, "_win_valid"}, 32'(bus.win_valid), 32'd0);
    check({tag, "_rd_base"},   32'(bus.rd_base),   32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_out_row"},   32'(bus.out_row),   32'd0);
    check({tag, "_out_col"},   32'(bus.out_col),   32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
  endtask

  task automatic start_and_load(input int gap, input bit disturb);
    clear_logs();
    bus.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
`ifdef CONVO_FRAME_CTRL_ERR_EN
    check("err_clear_on_start", 32'(bus.err), 32'd0);
`endif
    for (int i = 0; i < N*N; i++) begin
      bus.pix_valid = 1'b1;
      bus.start     = disturb && (i == 50);
      tick();
      bus.pix_valid = 1'b0;
      bus.start     = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  task automatic run_frame(input int gap, input bit disturb);
    start_and_load(gap, disturb);
    if (disturb) begin
      repeat (5) tick();
      for (int d = 0; d < 3; d++) begin
        bus.start     = 1'b1;
        bus.pix_valid = 1'b1;
        #1;
        check("wr_en_in_compute", 32'(bus.wr_en), 32'd0);
        tick();
      end
      bus.start     = 1'b0;
      bus.pix_valid = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_frame(input string tag, input int exp_lat);
    int bad;
    check({tag, "_nwr"}, 32'(q_wr.size()), 32'(N*N));
    bad = 0;
    foreach (q_wr[i]) if (q_wr[i] != ADDR_W'(i)) bad++;
    check({tag, "_wr_seq_bad"}, 32'(bad), 32'd0);
    check({tag, "_nwin"}, 32'(q_win.size()), 32'(WINS));
    bad = 0;
    foreach (q_win[i]) if (q_win[i] != ADDR_W'((i/(N-2))*N + i%(N-2))) bad++;
    check({tag, "_rd_base_seq_bad"}, 32'(bad), 32'd0);
    check({tag, "_nres"}, 32'(q_res.size()), 32'(WINS));
    bad = 0;
    foreach (q_res[i]) if (q_res[i] != {CNT_W'(i/(N-2)), CNT_W'(i%(N-2))}) bad++;
    check({tag, "_rowcol_seq_bad"}, 32'(bad), 32'd0);
    if (q_res.size() > 0) check({tag, "_last_rowcol"}, 32'(q_res[q_res.size()-1]), 32'h77);
    check({tag, "_win_lat"},  32'(first_win_cyc - last_wr_cyc),  32'd1);
    check({tag, "_res_lat"},  32'(first_res_cyc - first_win_cyc), 32'(PIPE_LAT));
    check({tag, "_res_span"}, 32'(last_res_cyc - first_res_cyc),  32'(WINS-1));
    check({tag, "_done_lat"}, 32'(done_cyc - last_res_cyc),       32'd1);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_at_done"},     32'(busy_at_done),     32'd0);
    check({tag, "_busy_before_done"}, 32'(busy_before_done), 32'd1);
    if (exp_lat > 0) check({tag, "_start_to_done"}, 32'(done_cyc - start_cyc), 32'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    clear_logs();
    repeat (3) tick();
    check_outputs_zero("rst");
`ifdef CONVO_FRAME_CTRL_ERR_EN
    check("rst_err", 32'(bus.err), 32'd0);
`endif
    reset = 1'b0;
    tick();
    // pix_valid in IDLE must not write or start anything
    for (int i = 0; i < 3; i++) begin
      bus.pix_valid = 1'b1;
      #1;
      check("idle_wr_en", 32'(bus.wr_en), 32'd0);
      tick();
    end
    bus.pix_valid = 1'b0;
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Consecutive pixels: start at S, done at S+1+100+64+4 = S+169
    run_frame(1, 1'b0);
    check_frame("contig", 169);
    tick();

    // Pixel every third cycle
    run_frame(3, 1'b0);
    check_frame("gap3", 0);
    repeat (3) tick();

    // Misuse: start in LOAD and COMPUTE, pixels in COMPUTE
    run_frame(1, 1'b1);
    check_frame("disturb", 169);
    repeat (20) tick();
    check("disturb_single_done", 32'(done_cnt), 32'd1);
`ifdef CONVO_FRAME_CTRL_ERR_EN
    check("disturb_err_sticky", 32'(bus.err), 32'd1);
`endif

    // Back-to-back frames: second start in the cycle after done
    run_frame(1, 1'b0);
    check_frame("b2b_first", 169);
    run_frame(1, 1'b0);
    check_frame("b2b_second", 169);
    repeat (2) tick();

    // Abort after the 20th window with an asynchronous mid-cycle reset
    start_and_load(1, 1'b0);
    n = 0;
    while (q_win.size() < 20 && n < 200) begin
      tick();
      n++;
    end
    check("abort_reached_20", 32'(q_win.size()), 32'd20);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    tick();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    run_frame(1, 1'b0);
    check_frame("after_abort", 169);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end
endmodule

// File: doc/convo_frame_ctrl.md
Name: convo_frame_ctrl

Overview:
Sequencer for the RGB 3x3 convolution datapath. Runs one frame per start pulse:
- Loads N*N streamed pixels into the datapath pixel memory.
- Walks all (N-2)*(N-2) valid 3x3 window positions, issuing one window per cycle.
- Tracks result validity through the datapath pipeline and signals frame completion.
Sits between the pixel source and the convolution datapath, replacing ad-hoc testbench timing (fixed delays, data_in_en toggling).

Parameters:
N, 10, image side length in pixels (N >= 3)
ADDR_W, 7, pixel-memory address width; must satisfy 2**ADDR_W >= N*N
CNT_W, 4, row/col counter width; must satisfy 2**CNT_W >= N-2
PIPE_LAT, 4, cycles from win_valid to the matching Convo_final being valid (>= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle pulse; begins a frame when idle
pix_valid  in  1  RGB pixel present on the datapath inputs this cycle
wr_en  out  1  pixel-memory write strobe
wr_addr  out  ADDR_W  pixel-memory write address
win_valid  out  1  rd_base holds a valid window this cycle
rd_base  out  ADDR_W  top-left address of the current 3x3 window (row*N+col)
res_valid  out  1  Convo_final is valid this cycle
out_row  out  CNT_W  output-pixel row of the current res_valid
out_col  out  CNT_W  output-pixel column of the current res_valid
busy  out  1  high in LOAD, COMPUTE and DRAIN
done  out  1  one-cycle pulse after the last result

Behaviour:
- Reset (async assert): state=IDLE; all outputs 0; all counters 0; PIPE_LAT shift register cleared. Applies identically mid-frame; any partial frame is abandoned, with no done pulse.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD next cycle; load counter=0.
  - pix_valid ignored.
- LOAD:
  - wr_en = pix_valid (combinational, same cycle); wr_addr = load counter (registered).
  - Counter increments on each pix_valid. Gaps in pix_valid are allowed.
  - On the write at address N*N-1 -> COMPUTE next cycle.
- COMPUTE:
  - win_valid=1 every cycle (registered outputs).
  - rd_base starts at 0 and advances +1 within a row.
  - At col=N-3, rd_base advances +3 and row increments.
  - After issuing row=col=N-3 (address (N-3)*N+N-3) -> DRAIN. Total of (N-2)^2 windows.
- DRAIN:
  - win_valid=0.
  - Remain until the final res_valid has been emitted, then -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Result tracking:
  - res_valid = win_valid delayed PIPE_LAT cycles.
  - out_row/out_col are the window row/col delayed identically; they hold the last value when res_valid=0.
  - Exactly (N-2)^2 res_valid pulses per frame.
- busy = (state is LOAD, COMPUTE or DRAIN).
- start while busy or in DONE: ignored.
- pix_valid outside LOAD: wr_en stays 0.
- Latency:
  - First win_valid occurs 1 cycle after the last LOAD write.
  - First res_valid occurs PIPE_LAT cycles after the first win_valid.
  - done occurs 1 cycle after the last res_valid.
- Simultaneous start and reset: reset wins.

Optional Feature:
CONVO_FRAME_CTRL_ERR_EN
- Defined: adds output port err (1 bit, sticky). Set on start while busy, or on pix_valid in COMPUTE/DRAIN/DONE. Cleared only by reset or by an accepted start.
- Undefined: the port is absent; these events are silently ignored, with identical behaviour otherwise.

Test Plan:
- Reset asserted mid-clock with outputs active -> all outputs 0 immediately without a clock edge; state IDLE after release.
- N=10, start, then 100 consecutive pix_valid -> wr_addr 0..99 with wr_en on each. Then 64 win_valid cycles with rd_base 0..7,10..17,...,70..77. res_valid 64 pulses starting 4 cycles after the first win_valid; last pulse has out_row=7, out_col=7. done single pulse 1 cycle later; busy drops together with done.
- pix_valid asserted every third cycle in LOAD -> exactly 100 writes, addresses contiguous 0..99, no writes during gaps; compute phase identical to the previous case.
- start pulses during LOAD and COMPUTE, plus pix_valid during COMPUTE -> no restart, wr_en stays 0, rd_base sequence unchanged, exactly one done. With ERR_EN: err=1 held until the next accepted start.
- Reset asserted after the 20th window, then released, then a new start with a full frame -> no done from the aborted frame; the new frame gives 64 res_valid pulses and one done.
- Back-to-back frames (start 1 cycle after done) -> second frame wr_addr restarts at 0; second done occurs at the same relative latency as the first.
